// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
//
// Multi-cycle shift controller for the ALU shift path.  A command (operation,
// operand, amount) is captured on an accepted start.  One single-bit shift is
// then performed per clock until the amount is used up, and a one-cycle done
// pulse reports the result with its carry and zero flags.
//
// Ports:
//   clk      in   1       system clock, rising-edge active
//   rst      in   1       asynchronous active-high reset
//   start    in   1       command strobe, accepted while idle or done
//   op       in   2       00=LSL 01=LSR 10=ASR 11=ROL
//   operand  in   WIDTH   value to shift, captured with start
//   amount   in   AMT_W   number of 1-bit steps, captured with start
//   busy     out  1       high while shift steps are in progress
//   done     out  1       one-cycle pulse, result/carry/zero valid
//   result   out  WIDTH   shifted value, held until the next accepted start
//   carry    out  1       last bit shifted or rotated out (0 for amount 0)
//   zero     out  1       result == 0
// ---------------------------------------------------------------------------
module shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    state_t           state;
    logic [1:0]       op_reg;
    logic [AMT_W-1:0] counter;

    // One single-bit shift step.  Returns {bit shifted out, new value}.
    function automatic logic [WIDTH:0] shift_step(input logic [1:0]       sop,
                                                  input logic [WIDTH-1:0] r);
        logic [WIDTH:0] res;
        res = '0;
        case (sop)
            OP_LSL:  res = {r[WIDTH-1], r[WIDTH-2:0], 1'b0};
            OP_LSR:  res = {r[0], 1'b0, r[WIDTH-1:1]};
            OP_ASR:  res = {r[0], r[WIDTH-1], r[WIDTH-1:1]};
            OP_ROL:  res = {r[WIDTH-1], r[WIDTH-2:0], r[WIDTH-1]};
            default: res = {1'b0, r};
        endcase
        return res;
    endfunction

    // Sequencer: idle and done both accept a new command so that commands can
    // run back to back without an idle cycle.  An amount of zero goes straight
    // to done with the operand passed through unchanged.  In shift, the step
    // that sees counter == 1 is the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            op_reg  <= OP_LSL;
            counter <= '0;
            result  <= '0;
            carry   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_reg <= op;
                        result <= operand;
                        carry  <= 1'b0;
                        if (amount == '0) begin
                            counter <= '0;
                            state   <= S_DONE;
                        end else begin
                            counter <= amount;
                            state   <= S_SHIFT;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    {carry, result} <= shift_step(op_reg, result);
                    counter         <= counter - 1'b1;
                    if (counter == AMT_W'(1)) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Status flags decode directly from the state register, so they are
    // mutually exclusive and glitch-free.
    assign busy = (state == S_SHIFT);
    assign done = (state == S_DONE);
    assign zero = (result == '0);

endmodule

// File: tb/tb_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shift_sequencer
//
// Self-checking bench for shift_sequencer.  A timeline model tracks, per
// clock edge, when each accepted command must show busy and done, and the
// final result/carry of a command is computed with whole-word arithmetic
// (shift by k at once, rotate modulo WIDTH) rather than stepping bit by bit.
// Directed commands with hand-worked answers pin the model, then randomized
// traffic (including starts while busy) runs against it.
// ---------------------------------------------------------------------------
module tb_shift_sequencer;

    localparam int WIDTH = 4;
    localparam int AMT_W = 3;

    logic             clk;
    logic             rst;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand;
    logic [AMT_W-1:0] amount;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;

    int vectors;
    int miscompares;

    // Timeline model state: edge counter, capture edge of the last accepted
    // command, edge after which its done pulse shows, and its final answer.
    int               edge_n;
    int               cap_edge;
    int               done_edge;
    logic [WIDTH-1:0] exp_r;
    logic             exp_c;

    shift_sequencer #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .operand (operand),
        .amount  (amount),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .carry   (carry),
        .zero    (zero)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not hold.
    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Whole-command answer: {carry, result} of shifting v by k in one go.
    function automatic logic [WIDTH:0] modelCmd(input logic [1:0] mop, input int v, input int k);
        int sv;
        int res;
        int c;
        int m;
        res = v;
        c   = 0;
        case (mop)
            2'b00: begin
                res = (v << k) & ((1 << WIDTH) - 1);
                c   = (k == 0) ? 0 : ((v << k) >> WIDTH) & 1;
            end
            2'b01: begin
                res = v >> k;
                c   = (k == 0) ? 0 : (v >> (k - 1)) & 1;
            end
            2'b10: begin
                sv  = (v >= (1 << (WIDTH - 1))) ? v - (1 << WIDTH) : v;
                res = (sv >>> k) & ((1 << WIDTH) - 1);
                c   = (k == 0) ? 0 : (sv >>> (k - 1)) & 1;
            end
            default: begin
                m   = k % WIDTH;
                res = ((v << m) | (v >> (WIDTH - m))) & ((1 << WIDTH) - 1);
                c   = (k == 0) ? 0 : res & 1;
            end
        endcase
        return {c[0], res[WIDTH-1:0]};
    endfunction

    task automatic modelReset();
        cap_edge  = -100;
        done_edge = -100;
        exp_r     = '0;
        exp_c     = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs that were driven
    // for it.  A command is accepted once the previous one has shown done.
    task automatic modelEdge();
        logic [WIDTH:0] ans;
        edge_n++;
        if (start && edge_n > done_edge) begin
            cap_edge  = edge_n;
            done_edge = edge_n + int'(amount);
            ans       = modelCmd(op, int'(operand), int'(amount));
            exp_r     = ans[WIDTH-1:0];
            exp_c     = ans[WIDTH];
        end
    endtask

    // The single per-cycle compare against the model.  Result and flags are
    // only meaningful from the done pulse until the next capture.
    task automatic checkOutput();
        compare("busy", 32'(busy), 32'(edge_n >= cap_edge && edge_n < done_edge));
        compare("done", 32'(done), 32'(edge_n == done_edge));
        if (edge_n >= done_edge) begin
            compare("result", 32'(result), 32'(exp_r));
            compare("carry", 32'(carry), 32'(exp_c));
            compare("zero", 32'(zero), 32'(exp_r == '0));
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then check.
    task automatic applyStimulus(input logic s, input logic [1:0] o,
                                 input logic [WIDTH-1:0] a, input logic [AMT_W-1:0] m);
        start   = s;
        op      = o;
        operand = a;
        amount  = m;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
        @(negedge clk);
    endtask

    // Issue one command and follow it to done, checking hand-worked answers,
    // edges from capture to done, and the number of busy cycles.  Inputs are
    // scrambled while the command runs to show they are not resampled.
    task automatic runDirected(input string name, input logic [1:0] o,
                               input logic [WIDTH-1:0] a, input logic [AMT_W-1:0] m,
                               input logic [WIDTH-1:0] er, input logic ec,
                               input int elat, input int ebusy);
        int   lat;
        int   bcnt;
        logic seen;
        applyStimulus(1'b1, o, a, m);
        lat  = 0;
        bcnt = busy ? 1 : 0;
        seen = done;
        while (!seen && lat < 40) begin
            applyStimulus(1'b0, ~o, ~a, ~m);
            lat++;
            if (busy) bcnt++;
            seen = done;
        end
        compare({name, " done_seen"}, 32'(seen), 32'd1);
        compare({name, " latency"}, 32'(lat), 32'(elat));
        compare({name, " busy_cycles"}, 32'(bcnt), 32'(ebusy));
        compare({name, " result"}, 32'(result), 32'(er));
        compare({name, " carry"}, 32'(carry), 32'(ec));
        compare({name, " zero"}, 32'(zero), 32'(er == '0));
    endtask

    // Assert reset partway through a clock low phase and check that the
    // outputs clear without waiting for an edge.
    task automatic midCycleReset();
        #2;
        rst = 1'b1;
        #1;
        compare("rst busy", 32'(busy), 32'd0);
        compare("rst done", 32'(done), 32'd0);
        compare("rst result", 32'(result), 32'd0);
        compare("rst carry", 32'(carry), 32'd0);
        compare("rst zero", 32'(zero), 32'd1);
        modelReset();
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic held_busy [8];
        logic held_done [8];
        logic [1:0] hb_exp;
        vectors     = 0;
        miscompares = 0;
        edge_n      = 0;
        modelReset();
        rst     = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        operand = '0;
        amount  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        compare("reset busy", 32'(busy), 32'd0);
        compare("reset zero", 32'(zero), 32'd1);

        // Idle with no start must stay quiet.
        repeat (3) applyStimulus(1'b0, 2'b00, 4'b1111, 3'd3);

        // Reset in the middle of a long shift; no done must appear afterwards.
        applyStimulus(1'b1, 2'b00, 4'b0011, 3'd7);
        applyStimulus(1'b0, 2'b00, 4'b0011, 3'd7);
        applyStimulus(1'b0, 2'b00, 4'b0011, 3'd7);
        midCycleReset();
        repeat (10) applyStimulus(1'b0, 2'b00, 4'b0000, 3'd0);

        // Hand-worked commands.
        runDirected("lsl_0011_1", 2'b00, 4'b0011, 3'd1, 4'b0110, 1'b0, 1, 1);
        runDirected("lsl_1001_2", 2'b00, 4'b1001, 3'd2, 4'b0100, 1'b0, 2, 2);
        runDirected("lsr_0110_3", 2'b01, 4'b0110, 3'd3, 4'b0000, 1'b1, 3, 3);
        runDirected("asr_1000_2", 2'b10, 4'b1000, 3'd2, 4'b1110, 1'b0, 2, 2);
        runDirected("rol_1001_5", 2'b11, 4'b1001, 3'd5, 4'b0011, 1'b1, 5, 5);
        runDirected("lsl_1010_0", 2'b00, 4'b1010, 3'd0, 4'b1010, 1'b0, 0, 0);
        runDirected("lsl_1111_7", 2'b00, 4'b1111, 3'd7, 4'b0000, 1'b0, 7, 7);
        runDirected("asr_1010_6", 2'b10, 4'b1010, 3'd6, 4'b1111, 1'b1, 6, 6);
        runDirected("lsr_1000_4", 2'b01, 4'b1000, 3'd4, 4'b0000, 1'b1, 4, 4);

        // Start held high: starts during shift are ignored, a start during
        // done begins the next command immediately.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 2'b00, 4'b0001, 3'd2);
            held_busy[i] = busy;
            held_done[i] = done;
            if (i == 2) begin
                compare("held result", 32'(result), 32'h4);
                compare("held carry", 32'(carry), 32'd0);
            end
        end
        for (int i = 0; i < 8; i++) begin
            hb_exp = (i % 3 == 2) ? 2'b01 : 2'b10;
            compare("held busy", 32'(held_busy[i]), 32'(hb_exp[1]));
            compare("held done", 32'(held_done[i]), 32'(hb_exp[0]));
        end

        // Back-to-back zero-amount commands: one per cycle.
        applyStimulus(1'b0, 2'b00, 4'b0000, 3'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'(i), 4'(i * 5 + 1), 3'd0);
            compare("k0 done", 32'(done), 32'd1);
        end

        // Randomized traffic, with one reset dropped in part way.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                          4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
            if (i == 300) begin
                midCycleReset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
